// File: rtl/loader_pkg.sv
// Shared definitions for the boot-time program loader and the datapath
// (boot PC, default instruction-memory depth, loader FSM states).
package loader_pkg;

    localparam logic [31:0] BOOT_PC             = 32'h0040_0000;
    localparam int          DEFAULT_DEPTH_WORDS = 64;

    typedef enum logic [2:0] {
        HEADER,
        LOAD,
        CHECK,
        RUN,
        ERR
    } state_t;

endpackage

// File: rtl/program_loader.sv
// Boot loader: takes a framed word stream (count, program words, checksum),
// writes the program into instruction memory and holds the datapath in clear
// until the image is fully written and verified.
module program_loader
    import loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = BOOT_PC,
    parameter int          DEPTH_WORDS = DEFAULT_DEPTH_WORDS
) (
    input  logic        clock,
    input  logic        clear_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic        in_last,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        dp_clear,
    output logic        done,
    output logic        error
);

    localparam int CW = $clog2(DEPTH_WORDS + 1);

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] remaining;
    logic [31:0]   addr;
    logic [31:0]   sum;
    logic          accept;

    assign accept = in_valid && in_ready;

    always_comb begin
        state_next = state;
        if (accept) begin
            case (state)
                HEADER: begin
                    if (in_last || in_data == 32'd0 || in_data > 32'(DEPTH_WORDS))
                        state_next = ERR;
                    else
                        state_next = LOAD;
                end
                LOAD: begin
                    if (in_last)
                        state_next = ERR;
                    else if (remaining == CW'(1))
                        state_next = CHECK;
                end
                CHECK: begin
                    if (in_last && in_data == sum)
                        state_next = RUN;
                    else
                        state_next = ERR;
                end
                default: state_next = state;
            endcase
        end
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n)
            state <= HEADER;
        else
            state <= state_next;
    end

    // Status outputs are registered from the next state so they change on
    // the same edge that enters RUN/ERR; the final write strobe is already
    // committing on that edge, so dp_clear never drops before memory is full.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            remaining  <= '0;
            addr       <= BASE_ADDR;
            sum        <= '0;
            in_ready   <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= BASE_ADDR;
            imem_wdata <= '0;
            dp_clear   <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            in_ready <= (state_next != RUN) && (state_next != ERR);
            done     <= (state_next == RUN);
            error    <= (state_next == ERR);
            dp_clear <= (state_next != RUN);
            imem_we  <= 1'b0;
            if (accept) begin
                case (state)
                    HEADER: begin
                        remaining <= in_data[CW-1:0];
                        addr      <= BASE_ADDR;
                        sum       <= '0;
                    end
                    LOAD: begin
                        if (!in_last) begin
                            imem_we    <= 1'b1;
                            imem_addr  <= addr;
                            imem_wdata <= in_data;
                            sum        <= sum + in_data;
                            addr       <= addr + 32'd4;
                            remaining  <= remaining - CW'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: doc/program_loader.md
# program_loader

Upstream boot stage for the single-cycle datapath. It accepts a framed word stream (count header, program words, checksum), writes the program words into instruction memory starting at the reset PC, and holds the datapath in clear until the whole image has been written and the checksum matches. If the image is malformed, the loader parks in an error state and keeps the datapath held in clear.

## Interface
Parameters:
- BASE_ADDR, 32'h0040_0000, byte address of the first program word; equals the datapath reset PC.
- DEPTH_WORDS, 64, instruction memory capacity in words; valid header range is 1..DEPTH_WORDS.

Ports:
- clock  in  1  single clock, rising edge.
- clear_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  stream word valid.
- in_ready  out  1  loader can accept a word.
- in_data  in  32  stream word.
- in_last  in  1  marks the checksum word, which is the final word of the frame.
- imem_we  out  1  instruction-memory write strobe.
- imem_addr  out  32  byte address of the write.
- imem_wdata  out  32  write data.
- dp_clear  out  1  active-high clear to the datapath.
- done  out  1  image loaded and verified.
- error  out  1  frame rejected.

## Operation
- A word is accepted on a rising edge when in_valid && in_ready. Nothing happens on cycles without acceptance. in_data must stay stable while in_valid=1 and in_ready=0.
- States: HEADER, LOAD, CHECK, RUN, ERR.
- HEADER: the accepted word is N.
  - N==0 or N>DEPTH_WORDS → ERR.
  - Otherwise remaining←N, addr←BASE_ADDR, sum←0, then go to LOAD.
  - in_last=1 on the header word → ERR.
- LOAD: for each accepted word:
  - Register a write: imem_we=1, imem_addr=addr, imem_wdata=in_data.
  - sum←sum+in_data, modulo 2^32, carries dropped.
  - addr←addr+4.
  - remaining←remaining−1. When remaining reaches 0, go to CHECK.
  - in_last=1 on any LOAD word → ERR, and that word is not written.
- CHECK: the accepted word must equal sum and carry in_last=1. If so, go to RUN; otherwise go to ERR.
- RUN: in_ready=0, done=1, dp_clear=0. Stays in RUN until clear_n is asserted.
- ERR: in_ready=0, error=1, dp_clear=1. Stays in ERR until clear_n is asserted.
- Words offered in RUN or ERR are never accepted.
- clear_n asserted in any state, including mid-LOAD, returns the loader to HEADER immediately. It does not erase memory contents already written; the next frame overwrites them.
- Address arithmetic is 32-bit. Its maximum is BASE_ADDR+4·(DEPTH_WORDS−1), so it never wraps.

## Timing
- Reset values (while clear_n=0): state=HEADER, in_ready=0, imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0, dp_clear=1, done=0, error=0.
- in_ready is registered. It rises on the first clock edge after clear_n deasserts and stays 1 through HEADER/LOAD/CHECK. It drops on the same edge that enters RUN or ERR.
- Write latency: the word accepted at edge k appears as an imem_we pulse during cycle k..k+1 and is written by memory at edge k+1. imem_we is never high for two words at once; it is high for exactly one cycle per accepted LOAD word.
- Back-to-back acceptance (one word per cycle) is supported with no bubbles.
- Ordering guarantee: the final LOAD write commits no later than the edge that accepts the checksum word. dp_clear falls on that same edge, together with the registered done=1. The datapath therefore leaves clear only after all writes have committed.
- Minimum frame duration is N+2 accepted words (header, N program words, checksum).

## Structure
- Shared package loader_pkg holds:
  - The state enum (HEADER, LOAD, CHECK, RUN, ERR).
  - The constants BOOT_PC=32'h0040_0000 and the default DEPTH_WORDS. The datapath's PC reset value uses the same BOOT_PC.
- One module. The FSM, the counter/address registers and the checksum accumulator are small enough that no sub-module is warranted.
- Top-level integration: Datapath's clear is driven by dp_clear; the instruction memory gains a write port driven by imem_we/imem_addr/imem_wdata.

## Test plan
- Nominal frame, back-to-back: words 3, 0x00221820, 0x00221822, 0x00221824, then checksum 0x00664866 with in_last=1.
  - Expect writes to 0x400000, 0x400004 and 0x400008 with those data values.
  - Expect done=1, dp_clear=0 and in_ready=0 after the checksum edge.
  - The datapath then fetches 0x00221820 at PC 0x400000.
- Same frame with in_valid gaps of 1–3 cycles between words → identical writes, and no imem_we on idle cycles.
- Same frame with checksum 0x00664867 → error=1, dp_clear stays 1, done=0, and a subsequent offered word is not accepted.
- Header 0, and separately header DEPTH_WORDS+1 → ERR on the header edge, with no imem_we pulses.
- in_last=1 on the second program word of a 3-word frame → ERR, and only one write occurs (to 0x400000).
- clear_n pulsed low after 2 program words, then the full nominal frame sent → loader restarts at 0x400000, finishes with done=1, and the final memory matches the nominal frame.
